// File: rtl/mmu_paged.sv
// mmu_paged: 6809 paging MMU with an internal translation table, per-page write
// protection with sticky fault capture/FIRQ, and delayed user-mode entry after RTI.
`default_nettype none

module mmu_paged #(
    parameter int          TASK_BITS    = 5,
    parameter int          PAGE_BITS    = 3,
    parameter int          PHYS_BITS    = 7,
    parameter int          RTI_DELAY    = 1,
    parameter logic [15:0] IO_ADDR_MIN  = 16'hFC00,
    parameter logic [15:0] IO_ADDR_MAX  = 16'hFEFF,
    parameter logic [15:0] MMU_REG_BASE = 16'hFE10,
    parameter logic [15:0] MMU_RAM_BASE = 16'hFE20
) (
    input  logic                 CLKX4,
    input  logic                 RESET,
    input  logic                 E,
    input  logic [15:0]          ADDR,
    input  logic                 RnW,
    input  logic                 BA,
    input  logic                 BS,
    inout  wire  [7:0]           DATA,
    output logic [PHYS_BITS-1:0] PHYS,
    output logic                 nRD,
    output logic                 nWR,
    output logic                 nCSIO,
    output logic                 nFIRQ
);

    localparam int          IDX_BITS   = TASK_BITS + PAGE_BITS;
    localparam int          NPAGE      = 1 << PAGE_BITS;
    localparam logic [7:0]  ENTRY_MASK = 8'h80 | 8'((1 << PHYS_BITS) - 1);
    localparam logic [3:0]  RTI_LOAD   = 4'(RTI_DELAY);
    localparam logic [15:0] REG_END    = MMU_REG_BASE + 16'd7;
    localparam logic [15:0] RAM_END    = MMU_RAM_BASE + 16'd15;
    localparam logic [15:0] WIN_END    = MMU_RAM_BASE + 16'(NPAGE - 1);

    function automatic logic in_rng(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    logic [7:0] table_q [1 << IDX_BITS];

    // Bus sample registers, loaded on every edge while E is high
    logic                 e_q, rnw_q, ba_q, bs_q, wpb_q;
    logic [15:0]          addr_q;
    logic [7:0]           data_q;
    logic [TASK_BITS-1:0] stask_q;

    logic                 enmmu_q, wpen_q, irqen_q, u_q, pend_q, fault_q, nfirq_q;
    logic                 enmmu_d, wpen_d, irqen_d, u_d, pend_d, fault_d, nfirq_d;
    logic [TASK_BITS-1:0] akey_q, tkey_q, ftask_q, akey_d, tkey_d, ftask_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [15:0]          faddr_q, faddr_d;

    // Live (current bus) decode and translation
    logic                 cur_vec, cur_io, cur_reg, cur_ram, cur_win, wp_block, drive;
    logic [TASK_BITS-1:0] cur_task;
    logic [PAGE_BITS-1:0] cur_page, cur_woff;
    logic [2:0]           cur_roff;
    logic [7:0]           cur_entry, rdata;

    assign cur_vec   = !BA && BS && RnW;
    assign cur_io    = in_rng(ADDR, IO_ADDR_MIN, IO_ADDR_MAX);
    assign cur_reg   = in_rng(ADDR, MMU_REG_BASE, REG_END);
    assign cur_ram   = in_rng(ADDR, MMU_RAM_BASE, RAM_END);
    assign cur_win   = in_rng(ADDR, MMU_RAM_BASE, WIN_END);
    assign cur_roff  = 3'(ADDR - MMU_REG_BASE);
    assign cur_woff  = PAGE_BITS'(ADDR - MMU_RAM_BASE);
    assign cur_task  = (u_q && !cur_vec) ? tkey_q : '0;
    assign cur_page  = ADDR[15 -: PAGE_BITS];
    assign cur_entry = table_q[{cur_task, cur_page}];

    assign wp_block = E && !RnW && enmmu_q && wpen_q && u_q && !cur_io && cur_entry[7];
    assign nRD      = !(E && RnW);
    assign nWR      = !(E && !RnW && !wp_block);
    assign nCSIO    = !(cur_io && !(cur_reg || cur_ram));
    assign nFIRQ    = nfirq_q;

    always_comb begin
        PHYS = cur_entry[PHYS_BITS-1:0];
        if (!enmmu_q)
            PHYS = PHYS_BITS'(cur_page);
        else if (cur_io)
            PHYS = '1;
    end

    always_comb begin
        rdata = 8'h00;
        if (cur_reg) begin
            case (cur_roff)
                3'd0: rdata = {4'b0000, irqen_q, !u_q, wpen_q, enmmu_q};
                3'd1: rdata = 8'(akey_q);
                3'd2: rdata = 8'(tkey_q);
                3'd3: rdata = 8'h3B;
                3'd4: rdata = {7'b0000000, fault_q};
                3'd5: rdata = faddr_q[15:8];
                3'd6: rdata = faddr_q[7:0];
                default: rdata = 8'(ftask_q);
            endcase
        end else if (cur_win) begin
            rdata = table_q[{akey_q, cur_woff}];
        end
    end

    assign drive = E && RnW && (cur_reg || cur_ram);
    assign DATA  = drive ? rdata : 8'bz;

    // Commit-side decode, from the registered bus copy
    logic                 commit, cmt_vec, cmt_wr, cmt_reg, cmt_win, cmt_arm;
    logic [2:0]           cmt_roff;
    logic [PAGE_BITS-1:0] cmt_woff;

    assign commit   = e_q && !E;
    assign cmt_vec  = !ba_q && bs_q && rnw_q;
    assign cmt_reg  = in_rng(addr_q, MMU_REG_BASE, REG_END);
    assign cmt_win  = in_rng(addr_q, MMU_RAM_BASE, WIN_END);
    assign cmt_roff = 3'(addr_q - MMU_REG_BASE);
    assign cmt_woff = PAGE_BITS'(addr_q - MMU_RAM_BASE);
    assign cmt_wr   = commit && !rnw_q && !u_q;
    assign cmt_arm  = commit && rnw_q && cmt_reg && (cmt_roff == 3'd3) && !u_q;

    always_comb begin
        enmmu_d = enmmu_q;
        wpen_d  = wpen_q;
        irqen_d = irqen_q;
        akey_d  = akey_q;
        tkey_d  = tkey_q;
        u_d     = u_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        fault_d = fault_q;
        faddr_d = faddr_q;
        ftask_d = ftask_q;
        nfirq_d = !(fault_q && irqen_q);

        if (cmt_wr && cmt_reg) begin
            case (cmt_roff)
                3'd0: begin
                    enmmu_d = data_q[0];
                    wpen_d  = data_q[1];
                    irqen_d = data_q[3];
                end
                3'd1: akey_d = data_q[TASK_BITS-1:0];
                3'd2: tkey_d = data_q[TASK_BITS-1:0];
                3'd4: fault_d = 1'b0;
                default: ;
            endcase
        end

        if (commit && wpb_q) begin
            fault_d = 1'b1;
            if (!fault_q) begin
                faddr_d = addr_q;
                ftask_d = stask_q;
            end
        end

        // Vector fetch has priority over arming and over a pending count
        if (commit) begin
            if (cmt_vec) begin
                u_d    = 1'b0;
                pend_d = 1'b0;
            end else if (cmt_arm) begin
                if (RTI_LOAD == 4'd0) begin
                    u_d    = 1'b1;
                    pend_d = 1'b0;
                end else begin
                    cnt_d  = RTI_LOAD;
                    pend_d = 1'b1;
                end
            end else if (pend_q) begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    u_d    = 1'b1;
                    pend_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            e_q     <= 1'b0;
            addr_q  <= '0;
            rnw_q   <= 1'b1;
            data_q  <= '0;
            ba_q    <= 1'b0;
            bs_q    <= 1'b0;
            wpb_q   <= 1'b0;
            stask_q <= '0;
            enmmu_q <= 1'b0;
            wpen_q  <= 1'b0;
            irqen_q <= 1'b0;
            akey_q  <= '0;
            tkey_q  <= '0;
            u_q     <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            fault_q <= 1'b0;
            faddr_q <= '0;
            ftask_q <= '0;
            nfirq_q <= 1'b1;
        end else begin
            e_q <= E;
            if (E) begin
                addr_q  <= ADDR;
                rnw_q   <= RnW;
                data_q  <= DATA;
                ba_q    <= BA;
                bs_q    <= BS;
                wpb_q   <= wp_block;
                stask_q <= cur_task;
            end
            enmmu_q <= enmmu_d;
            wpen_q  <= wpen_d;
            irqen_q <= irqen_d;
            akey_q  <= akey_d;
            tkey_q  <= tkey_d;
            u_q     <= u_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            fault_q <= fault_d;
            faddr_q <= faddr_d;
            ftask_q <= ftask_d;
            nfirq_q <= nfirq_d;
        end
    end

    // Table has no reset; a reset edge still blocks the write
    always_ff @(posedge CLKX4) begin
        if (!RESET && cmt_wr && cmt_win)
            table_q[{akey_q, cmt_woff}] <= data_q & ENTRY_MASK;
    end

endmodule

`default_nettype wire

// File: tb/tb_mmu_paged.sv
// tb_mmu_paged: directed self-checking bench for mmu_paged with default parameters.
`default_nettype none

module tb_mmu_paged;

    logic        CLKX4 = 1'b0;
    logic        RESET, E, RnW, BA, BS;
    logic [15:0] ADDR;
    wire  [7:0]  DATA;
    logic [6:0]  PHYS;
    logic        nRD, nWR, nCSIO, nFIRQ;

    logic       tb_drv;
    logic [7:0] tb_data;
    logic [7:0] s_data;
    logic [6:0] s_phys;
    logic       s_nwr;
    int         n_checks = 0;
    int         n_fail   = 0;

    assign DATA = tb_drv ? tb_data : 8'bz;

    always #5 CLKX4 = ~CLKX4;

    mmu_paged dut (
        .CLKX4 (CLKX4),
        .RESET (RESET),
        .E     (E),
        .ADDR  (ADDR),
        .RnW   (RnW),
        .BA    (BA),
        .BS    (BS),
        .DATA  (DATA),
        .PHYS  (PHYS),
        .nRD   (nRD),
        .nWR   (nWR),
        .nCSIO (nCSIO),
        .nFIRQ (nFIRQ)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: two CLKX4 edges with E high, commit on the first edge with E low
    task automatic bus(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                       input logic ba, input logic bs);
        @(negedge CLKX4);
        ADDR = a; RnW = rnw; BA = ba; BS = bs; tb_data = d; tb_drv = !rnw; E = 1'b1;
        @(negedge CLKX4);
        s_data = DATA; s_phys = PHYS; s_nwr = nWR;
        @(negedge CLKX4);
        E = 1'b0;
        @(posedge CLKX4);
        #1;
        tb_drv = 1'b0; BA = 1'b1; BS = 1'b0; RnW = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(a, 1'b0, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        bus(a, 1'b1, 8'h00, 1'b1, 1'b0);
        check(tag, {8'h00, s_data}, {8'h00, exp});
    endtask

    task automatic probe(input logic [15:0] a);
        @(negedge CLKX4);
        ADDR = a;
        #1;
    endtask

    initial begin
        RESET = 1'b1; E = 1'b0; RnW = 1'b1; BA = 1'b1; BS = 1'b0;
        ADDR = 16'h0000; tb_drv = 1'b0; tb_data = 8'h00;
        repeat (3) @(posedge CLKX4);
        @(negedge CLKX4);
        RESET = 1'b0;
        check("rst_nfirq", {15'd0, nFIRQ}, 16'd1);

        // Reset register image; the FE13 read arms and FE14 commit enters user mode
        rd("rst_fe10", 16'hFE10, 8'h04);
        rd("rst_fe11", 16'hFE11, 8'h00);
        rd("rst_fe12", 16'hFE12, 8'h00);
        rd("rst_fe13", 16'hFE13, 8'h3B);
        rd("rst_fe14", 16'hFE14, 8'h00);
        rd("rst_fe15", 16'hFE15, 8'h00);
        rd("rst_fe16", 16'hFE16, 8'h00);
        rd("rst_fe17", 16'hFE17, 8'h00);
        rd("user_after_arm", 16'hFE10, 8'h00);
        bus(16'hFFF8, 1'b1, 8'h00, 1'b0, 1'b1);
        check("vec_phys_nommu", {9'd0, s_phys}, 16'h0007);
        rd("super_after_vec", 16'hFE10, 8'h04);

        // Table setup: task 0 unprotected, task 3 all write-protected
        wr(16'hFE11, 8'h00);
        for (int i = 0; i < 8; i++) wr(16'hFE20 + 16'(i), 8'h08 + 8'(i));
        wr(16'hFE11, 8'h03);
        for (int i = 0; i < 8; i++) wr(16'hFE20 + 16'(i), 8'h80 + 8'(i));
        rd("win_first", 16'hFE20, 8'h80);
        rd("win_last", 16'hFE27, 8'h87);
        rd("win_above", 16'hFE28, 8'h00);
        rd("win_top", 16'hFE2F, 8'h00);
        rd("akey", 16'hFE11, 8'h03);
        wr(16'hFE12, 8'h03);
        wr(16'hFE10, 8'h0B);
        rd("ctrl_en", 16'hFE10, 8'h0F);

        probe(16'h4000);
        check("phys_super", {9'd0, PHYS}, 16'h000A);
        probe(16'hFD00);
        check("phys_io", {9'd0, PHYS}, 16'h007F);
        check("csio_io", {15'd0, nCSIO}, 16'd0);
        probe(16'hFE10);
        check("csio_internal", {15'd0, nCSIO}, 16'd1);

        // RTI delay of one committed bus cycle
        rd("arm_fe13", 16'hFE13, 8'h3B);
        rd("rti_pending", 16'hFE10, 8'h0F);
        rd("rti_user", 16'hFE10, 8'h0B);
        probe(16'h4000);
        check("phys_user", {9'd0, PHYS}, 16'h0002);

        // Write-protect fault
        wr(16'h4000, 8'h55);
        check("wp_nwr", {15'd0, s_nwr}, 16'd1);
        check("firq_at_commit", {15'd0, nFIRQ}, 16'd1);
        @(posedge CLKX4);
        #1;
        check("firq_next", {15'd0, nFIRQ}, 16'd0);
        rd("fault_st", 16'hFE14, 8'h01);
        rd("fault_hi", 16'hFE15, 8'h40);
        rd("fault_lo", 16'hFE16, 8'h00);
        rd("fault_task", 16'hFE17, 8'h03);
        wr(16'h6000, 8'h66);
        check("wp_nwr2", {15'd0, s_nwr}, 16'd1);
        rd("fault_hi_sticky", 16'hFE15, 8'h40);
        rd("fault_lo_sticky", 16'hFE16, 8'h00);
        wr(16'hFD00, 8'h12);
        check("io_nwr", {15'd0, s_nwr}, 16'd0);

        // User-mode writes to MMU state are dropped
        wr(16'hFE12, 8'h07);
        wr(16'hFE20, 8'h55);
        rd("user_tkey", 16'hFE12, 8'h03);
        rd("user_win", 16'hFE20, 8'h80);
        rd("user_fault", 16'hFE14, 8'h01);

        // Vector fetch uses task 0 in the same cycle and leaves user mode
        bus(16'hFFF8, 1'b1, 8'h00, 1'b0, 1'b1);
        check("vec_phys", {9'd0, s_phys}, 16'h000F);
        rd("vec_super", 16'hFE10, 8'h0F);

        wr(16'hFE14, 8'h00);
        rd("fault_clr", 16'hFE14, 8'h00);
        check("firq_clr", {15'd0, nFIRQ}, 16'd1);

        // Vector cancels a pending RTI count
        rd("rearm", 16'hFE13, 8'h3B);
        bus(16'hFFF8, 1'b1, 8'h00, 1'b0, 1'b1);
        rd("cancel_a", 16'hFE10, 8'h0F);
        rd("cancel_b", 16'hFE10, 8'h0F);

        // Reset across the commit edge of a ctrl write
        @(negedge CLKX4);
        ADDR = 16'hFE10; RnW = 1'b0; tb_data = 8'h0B; tb_drv = 1'b1; E = 1'b1;
        @(negedge CLKX4);
        RESET = 1'b1;
        @(negedge CLKX4);
        E = 1'b0;
        @(posedge CLKX4);
        @(negedge CLKX4);
        RESET = 1'b0; tb_drv = 1'b0; RnW = 1'b1;
        rd("abort_ctrl", 16'hFE10, 8'h04);
        rd("abort_akey", 16'hFE11, 8'h00);
        rd("abort_table", 16'hFE20, 8'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mmu_paged.md
Name: mmu_paged

Overview:
- Next-generation 6809 paging MMU with parametrised task count, page size and physical page width.
- Translation table is held internally, so no external MMU SRAM is needed.
- Adds per-page write protection with a sticky fault capture and FIRQ, plus a configurable delayed user-mode entry after RTI.
- Sits between the CPU bus and the memory/IO chip selects. All state is clocked from the CPU's 4x clock, with bus cycles delimited by E.

Parameters:
TASK_BITS, 5, log2 of number of tasks (1..5)
PAGE_BITS, 3, log2 of pages per 64K map (1..4); page = ADDR[15:16-PAGE_BITS]
PHYS_BITS, 7, physical page number width (PAGE_BITS..7)
RTI_DELAY, 1, committed bus cycles between the FE13 trigger read and U becoming 1 (0..15)
IO_ADDR_MIN, 16'hFC00, start of untranslated IO region
IO_ADDR_MAX, 16'hFEFF, end of IO region
MMU_REG_BASE, 16'hFE10, base of 8 control registers
MMU_RAM_BASE, 16'hFE20, base of table window (2^PAGE_BITS bytes)

Ports:
CLKX4  in  1  sole clock, rising edge; E is synchronous to it
RESET  in  1  synchronous, active-high reset
E  in  1  CPU E; bus cycle commits on the CLKX4 edge where E was 1 last cycle and is now 0
ADDR  in  16  CPU address
RnW  in  1  CPU read/not-write
BA  in  1  CPU bus available
BS  in  1  CPU bus status
DATA  inout  8  CPU data; driven only when E & RnW & (register or window address)
PHYS  out  PHYS_BITS  translated physical page
nRD  out  1  !(E & RnW)
nWR  out  1  !(E & !RnW & !wp_block)
nCSIO  out  1  low for IO region not internal to this block
nFIRQ  out  1  fault interrupt, active low

Behaviour:
- Bus sampling: ADDR/RnW/DATA/BA/BS are registered on every CLKX4 edge while E=1. Register/table updates use the registered copy at the commit edge. Writes take effect from the next bus cycle.
- vector = !BA & BS & RnW (combinational). Translation task = (U & !vector) ? task_key : 0.
- PHYS (combinational):
  - enmmu=0: page index zero-extended.
  - IO region: all-ones.
  - otherwise: table[task][page][PHYS_BITS-1:0].
- Table entry is 8 bits = {WP, pad 0s, phys}. Table is not cleared by RESET; contents are undefined until written.
- Registers (offset from MMU_REG_BASE):
  - 0 ctrl: b0 enmmu, b1 wpen, b2 !U (read-only), b3 irqen.
  - 1 access_key.
  - 2 task_key.
  - 3 read returns 8'h3B and arms the RTI counter.
  - 4 fault status: b0 fault; write any value clears it.
  - 5/6 fault address hi/lo.
  - 7 fault task.
  - Key fields are TASK_BITS wide and zero-extended on read.
- Window: offset i (i < 2^PAGE_BITS) reads/writes table[access_key][i]. Addresses above the window, up to MMU_RAM_BASE+15, read 0.
- Protection: while U=1, register and window writes are ignored and reads still work. The FE13 arm is ignored while U=1.
- RTI counter:
  - Arm loads RTI_DELAY.
  - Each later commit decrements it; U<=1 at the commit where the count reaches 0.
  - RTI_DELAY=0 sets U at the arming commit itself.
  - Re-arming while pending reloads the count.
- Vector fetch: at commit, U<=0 and any pending RTI count is cancelled. Vector beats arming in the same cycle.
- Write fault: wp_block = E & !RnW & enmmu & wpen & U & !io & entry.WP.
  - Combinationally suppresses nWR.
  - At commit, fault<=1.
  - fault address/task are latched only if fault was 0 (first-fault sticky).
- nFIRQ = !(fault & irqen); it is registered, so it asserts one CLKX4 after the commit.
- Reset values: enmmu=wpen=irqen=0, keys=0, U=0, counter idle, fault=0, fault addr/task=0, nFIRQ=1, DATA hi-Z.
- Reset asserted mid-cycle aborts that commit; no register or table update occurs.

Test Plan:
- Reset then read FE10..FE17 -> 00,00,00 read of FE10 gives 04 (!U=1), FE13=3B, rest 00. nFIRQ=1.
- Write FE11=03, FE20..FE27=80+i, FE12=03, FE10=03. Read FE13 with RTI_DELAY=1 -> U=0 after 1st commit, U=1 after 2nd. Then ADDR=4000 gives PHYS=02.
- User write to page 2 (WP=1) -> nWR stays 1, fault=1, FE15/16=40xx, FE17=03. With irqen set, nFIRQ=0 one CLKX4 after commit. A second fault at 6000 leaves FE15=40.
- Vector fetch (BA=0,BS=1,RnW=1, ADDR=FFF8) while U=1 -> PHYS from task 0 in the same cycle, U=0 after commit. A pending RTI count is cancelled.
- In user mode, write FE12=07 and FE20=55 -> both ignored; readback unchanged.
- RESET high during a FE10 write cycle -> ctrl stays 00, and the table entry written before the reset is still readable afterwards.
